hub75_bcm_scanner: RTL and testbench
====================================

# hub75_bcm_scanner

Parametrised HUB75 panel scanner that reads a packed two-half framebuffer through a synchronous read port and drives one chain of LED panels. Colour depth is produced with binary-coded modulation (BCM): each bit plane is shifted, latched and shown for a time weighted by its bit position. Width, height, chain length, colour depth and shift-clock rate are parameters. The block sits between the framebuffer's display-side read port and the HUB75 connector pins.

## Interface

**Parameters**
- `PANEL_WIDTH`, 64: columns per panel.
- `CHAINED`, 1: number of panels in the chain. `W_TOTAL = PANEL_WIDTH*CHAINED`.
- `HEIGHT`, 64: panel rows. Scan rows `SCAN = HEIGHT/2`.
- `COLOR_BITS`, 4: bits per colour channel.
- `CLK_DIV`, 2: `i_clk` cycles per `o_sclk` half-period. Must be ≥2.
- `LSB_ON_CYCLES`, 8: OE-active cycles for bit plane 0.

**Ports**
- `i_clk`, in, 1: the single clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_enable`, in, 1: scanning enable.
- `o_ram_addr`, out, `ADDR_W`: framebuffer word address. The address is `row*W_TOTAL+col`; the bank bit is the MSB when swapping is compiled in.
- `o_ram_rd`, out, 1: read strobe. Data is returned on the following cycle.
- `i_ram_data`, in, `6*COLOR_BITS`: packed as `{R1,G1,B1,R0,G0,B0}`. Index 0 is the top-half row, index 1 is the bottom-half row (`row+SCAN`).
- `o_sclk`, `o_lat`, out, 1 each: HUB75 shift clock and latch.
- `o_oe_n`, out, 1: blank. A value of 1 means LEDs are off.
- `o_rgb0`, `o_rgb1`, out, 3 each: `{r,g,b}` data for the top and bottom halves.
- `o_row`, out, `clog2(SCAN)`: row select.
- `o_frame_done`, out, 1: one-cycle pulse at frame wrap.

## Operation

**FSM states:** IDLE, FETCH, SHIFT, LATCH, DISPLAY.

- **IDLE:** outputs blanked. Moves to FETCH when `i_enable=1`.
- **FETCH (2 cycles):** cycle 0 issues the read for column 0. Cycle 1 captures the data into the prefetch register.
- **SHIFT:** runs for `W_TOTAL` column slots of `2*CLK_DIV` cycles each.
  - Low phase (`CLK_DIV` cycles): `o_sclk=0`. `o_rgb*` carries bit `b` of column `c`, loaded from the prefetch register on the first low cycle.
  - High phase: `o_sclk=1`. The read for column `c+1` is issued on the first high cycle and captured on the next cycle.
  - No read is issued in the last column slot.
- **LATCH (2 cycles):** `o_sclk=0`, `o_lat=1`. `o_row` takes the current row on the first cycle.
- **DISPLAY:** `o_oe_n=0` for `LSB_ON_CYCLES<<b` cycles. Then, in order of precedence:
  - If `i_enable=0`, go to IDLE.
  - Otherwise, if `b<COLOR_BITS-1`, set `b++` and go to FETCH.
  - Otherwise set `b=0` and `row++`, then go to FETCH. When `row==SCAN-1`, it wraps to 0 and `o_frame_done` pulses on the first FETCH cycle.
- **Blanking:** `o_oe_n=1` in every state except DISPLAY. Shifting never overlaps display.
- **Counter widths:** the on-time counter is `clog2(LSB_ON_CYCLES<<(COLOR_BITS-1))+1` bits. The column counter is `clog2(W_TOTAL)` bits. Both are non-saturating and are reloaded on each state entry.

## Timing

- **Reset values:** `o_sclk=0`, `o_lat=0`, `o_oe_n=1`, `o_rgb0=o_rgb1=0`, `o_row=0`, `o_ram_rd=0`, `o_ram_addr=0`, `o_frame_done=0`, `o_bank=0`. State returns to IDLE with `row=0` and `b=0`.
- **Reset mid-operation:** reset values apply on the cycle after `i_rst` is sampled high, from any state.
- **Plane length:** `4 + 2*CLK_DIV*W_TOTAL + (LSB_ON_CYCLES<<b)` cycles. A frame is `SCAN` rows times the sum of all planes.
- **Read latency:** exactly one cycle. `CLK_DIV≥2` guarantees the data lands inside the high phase.
- **Enable deassertion:** takes effect only at the end of DISPLAY. A partial plane is never aborted.

## Configuration

- **`HUB75_BUFFER_SWAP_EN` defined:**
  - Adds input `i_swap_req` (1 bit) and output `o_bank` (1 bit).
  - `ADDR_W` gains one MSB driven by `o_bank`.
  - A pulse on `i_swap_req` sets a pending flag. `o_bank` toggles and the flag clears in the `o_frame_done` cycle.
  - A request sampled in the `o_frame_done` cycle applies at the next frame wrap.
- **Undefined:**
  - Neither port exists.
  - `ADDR_W=clog2(SCAN*W_TOTAL)`.

## Structure

- **Package `hub75_pkg`:** the FSM state enum, the pixel-word field offsets (`R0..B1` slices), and `clog2`-derived width constants.
- **Sub-module `hub75_bcm_timer`:** loads `LSB_ON_CYCLES<<b`, counts down, and asserts `done`. It is instantiated once.

## Test plan

All scenarios use `PANEL_WIDTH=4`, `CHAINED=1`, `HEIGHT=4`, `COLOR_BITS=2`, `CLK_DIV=2`, `LSB_ON_CYCLES=4`, with a memory model of one-cycle latency.

1. **Reset values:** hold `i_rst` for 3 cycles with `i_enable=1`. All outputs stay at reset values; `o_oe_n=1`.
2. **Shift data:** column `c` pixel R0 is `c[1:0]`. Plane 0 shows 4 `o_sclk` rising edges with `o_rgb0[2]` equal to 0,1,0,1 at each edge, followed by one 2-cycle `o_lat` pulse.
3. **BCM on-times:** `o_oe_n` is low for 4 cycles in plane 0 and 8 cycles in plane 1. Planes last 24 and 28 cycles.
4. **Row wrap:**
   - `o_row` goes 0→1→0.
   - `o_frame_done` pulses every 104 cycles, once per frame.
   - `o_ram_addr` for row 1 spans 4..7.
5. **Buffer swap** (macro defined): pulse `i_swap_req` mid-frame. `o_bank` flips in the `o_frame_done` cycle, and subsequent addresses have the MSB set. A second request in the `o_frame_done` cycle takes effect one frame later.
6. **Reset mid-shift:** assert `i_rst` at column 2. Next cycle shows reset values; scanning then restarts at row 0, plane 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types and width helpers for the HUB75 BCM scanner.
// Pixel word layout is {R1,G1,B1,R0,G0,B0}, one COLOR_BITS-wide field each.
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_e;

    localparam int FLD_B0     = 0;
    localparam int FLD_G0     = 1;
    localparam int FLD_R0     = 2;
    localparam int FLD_B1     = 3;
    localparam int FLD_G1     = 4;
    localparam int FLD_R1     = 5;
    localparam int NUM_FIELDS = 6;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int on_cnt_width(input int lsb_on, input int color_bits);
        return $clog2(lsb_on << (color_bits - 1)) + 1;
    endfunction

endpackage

// File: rtl/hub75_bcm_scanner_if.sv
// Framebuffer read port between the scanner (master) and the display-side RAM (slave).
// ram_rd is a one-cycle strobe with ram_addr valid alongside it; ram_data is valid the following cycle, no back-pressure.
interface hub75_bcm_scanner_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_data;

    modport master (output ram_addr, output ram_rd, input ram_data);
    modport slave  (input ram_addr, input ram_rd, output ram_data);
endinterface

// File: rtl/hub75_bcm_timer.sv
// BCM on-time down-counter: loads LSB_ON_CYCLES<<bit and flags the last on cycle.
module hub75_bcm_timer #(
    parameter int LSB_ON_CYCLES = 8,
    parameter int BIT_W         = 2,
    parameter int CNT_W         = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [BIT_W-1:0] i_bit,
    output logic             o_done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        if (i_load) begin
            cnt_d = CNT_W'(LSB_ON_CYCLES) << i_bit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scanner: fetch, shift, latch and display one BCM bit plane per pass, row by row.
// Define HUB75_BUFFER_SWAP_EN to add double-buffer bank selection (i_swap_req / o_bank).
module hub75_bcm_scanner
    import hub75_pkg::*;
#(
    parameter int PANEL_WIDTH   = 64,
    parameter int CHAINED       = 1,
    parameter int HEIGHT        = 64,
    parameter int COLOR_BITS    = 4,
    parameter int CLK_DIV       = 2,
    parameter int LSB_ON_CYCLES = 8,
    localparam int W_TOTAL      = PANEL_WIDTH * CHAINED,
    localparam int SCAN         = HEIGHT / 2,
    localparam int ROW_W        = width_of(SCAN),
    localparam int ADDR_LO_W    = width_of(SCAN * W_TOTAL),
`ifdef HUB75_BUFFER_SWAP_EN
    localparam int ADDR_W       = ADDR_LO_W + 1,
`else
    localparam int ADDR_W       = ADDR_LO_W,
`endif
    localparam int DATA_W       = 6 * COLOR_BITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    hub75_bcm_scanner_if.master ram,
    output logic                o_sclk,
    output logic                o_lat,
    output logic                o_oe_n,
    output logic [2:0]          o_rgb0,
    output logic [2:0]          o_rgb1,
    output logic [ROW_W-1:0]    o_row,
    output logic                o_frame_done,
`ifdef HUB75_BUFFER_SWAP_EN
    input  logic                i_swap_req,
    output logic                o_bank,
`endif
    output state_e              o_dbg_state
);

    localparam int COL_W = width_of(W_TOTAL);
    localparam int BIT_W = width_of(COLOR_BITS);
    localparam int PH_W  = width_of(2 * CLK_DIV);
    localparam int CNT_W = on_cnt_width(LSB_ON_CYCLES, COLOR_BITS);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ROW_W-1:0]  row_out_q, row_out_d;
    logic [DATA_W-1:0] pf_q, pf_d;
    logic [2:0]        rgb0_q, rgb0_d, rgb1_q, rgb1_d;
    logic              fd_q, fd_d;
    logic              timer_load, timer_done, wrap;
    logic              rd;
    logic [COL_W-1:0]  rd_col;
    logic [ADDR_LO_W-1:0] addr_lo;
    logic [ADDR_W-1:0]    addr_full;
    logic [COLOR_BITS-1:0] fld [NUM_FIELDS];

    always_comb begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
            fld[f] = pf_q[f*COLOR_BITS +: COLOR_BITS];
        end
    end

    // The next column is requested on the first high cycle so it lands before the slot ends.
    always_comb begin
        rd = ((state_q == ST_FETCH) && (ph_q == '0)) ||
             ((state_q == ST_SHIFT) && (ph_q == PH_W'(CLK_DIV)) &&
              (col_q != COL_W'(W_TOTAL - 1)));
        rd_col  = (state_q == ST_FETCH) ? '0 : col_q + COL_W'(1);
        addr_lo = '0;
        if (rd) begin
            addr_lo = ADDR_LO_W'(row_q) * ADDR_LO_W'(W_TOTAL) + ADDR_LO_W'(rd_col);
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q + PH_W'(1);
        col_d      = col_q;
        bit_d      = bit_q;
        row_d      = row_q;
        row_out_d  = row_out_q;
        pf_d       = pf_q;
        rgb0_d     = rgb0_q;
        rgb1_d     = rgb1_q;
        timer_load = 1'b0;
        wrap       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (i_enable) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ph_q == PH_W'(1)) begin
                    pf_d    = ram.ram_data;
                    ph_d    = '0;
                    col_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ph_q == '0) begin
                    rgb0_d = {fld[FLD_R0][bit_q], fld[FLD_G0][bit_q], fld[FLD_B0][bit_q]};
                    rgb1_d = {fld[FLD_R1][bit_q], fld[FLD_G1][bit_q], fld[FLD_B1][bit_q]};
                end
                if ((ph_q == PH_W'(CLK_DIV + 1)) && (col_q != COL_W'(W_TOTAL - 1))) begin
                    pf_d = ram.ram_data;
                end
                if (ph_q == PH_W'(2 * CLK_DIV - 1)) begin
                    ph_d = '0;
                    if (col_q == COL_W'(W_TOTAL - 1)) begin
                        row_out_d = row_q;
                        state_d   = ST_LATCH;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_LATCH: begin
                if (ph_q == PH_W'(1)) begin
                    ph_d       = '0;
                    timer_load = 1'b1;
                    state_d    = ST_DISPLAY;
                end
            end
            ST_DISPLAY: begin
                ph_d = '0;
                if (timer_done) begin
                    if (!i_enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                        if (bit_q != BIT_W'(COLOR_BITS - 1)) begin
                            bit_d = bit_q + BIT_W'(1);
                        end else begin
                            bit_d = '0;
                            if (row_q == ROW_W'(SCAN - 1)) begin
                                row_d = '0;
                                wrap  = 1'b1;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fd_d = wrap;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            col_q     <= '0;
            bit_q     <= '0;
            row_q     <= '0;
            row_out_q <= '0;
            pf_q      <= '0;
            rgb0_q    <= '0;
            rgb1_q    <= '0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            col_q     <= col_d;
            bit_q     <= bit_d;
            row_q     <= row_d;
            row_out_q <= row_out_d;
            pf_q      <= pf_d;
            rgb0_q    <= rgb0_d;
            rgb1_q    <= rgb1_d;
            fd_q      <= fd_d;
        end
    end

`ifdef HUB75_BUFFER_SWAP_EN
    logic bank_q, bank_d, pend_q, pend_d;

    // A request arriving on the wrap edge itself stays pending for the following wrap.
    always_comb begin
        bank_d = bank_q;
        pend_d = pend_q | i_swap_req;
        if (wrap && pend_q) begin
            bank_d = ~bank_q;
            pend_d = i_swap_req;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            pend_q <= pend_d;
        end
    end

    assign o_bank    = bank_q;
    assign addr_full = {bank_q, addr_lo};
`else
    assign addr_full = addr_lo;
`endif

    hub75_bcm_timer #(
        .LSB_ON_CYCLES (LSB_ON_CYCLES),
        .BIT_W         (BIT_W),
        .CNT_W         (CNT_W)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (timer_load),
        .i_bit  (bit_q),
        .o_done (timer_done)
    );

    assign ram.ram_addr = addr_full;
    assign ram.ram_rd   = rd;
    assign o_sclk       = (state_q == ST_SHIFT) && (ph_q >= PH_W'(CLK_DIV));
    assign o_lat        = (state_q == ST_LATCH);
    assign o_oe_n       = (state_q != ST_DISPLAY);
    assign o_rgb0       = rgb0_q;
    assign o_rgb1       = rgb1_q;
    assign o_row        = row_out_q;
    assign o_frame_done = fd_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner on a 4x4 panel, 2 colour bits, CLK_DIV=2, LSB on-time 4.
// Covers reset, shifted data, BCM on-times, row/frame wrap, reset mid-shift, enable drop and (with HUB75_BUFFER_SWAP_EN) bank swap.
module tb_hub75_bcm_scanner;
    import hub75_pkg::*;

`ifdef HUB75_BUFFER_SWAP_EN
    localparam int AW = 4;
`else
    localparam int AW = 3;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic en;
    always #5 clk = ~clk;

    logic       sclk, lat, oe_n, frame_done;
    logic [2:0] rgb0, rgb1;
    logic [0:0] row;
    state_e     dbg_state;
`ifdef HUB75_BUFFER_SWAP_EN
    logic swap_req;
    logic bank;
`endif

    hub75_bcm_scanner_if #(.ADDR_W(AW), .DATA_W(12)) ram_if ();

    hub75_bcm_scanner #(
        .PANEL_WIDTH(4), .CHAINED(1), .HEIGHT(4),
        .COLOR_BITS(2), .CLK_DIV(2), .LSB_ON_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .ram(ram_if),
        .o_sclk(sclk), .o_lat(lat), .o_oe_n(oe_n),
        .o_rgb0(rgb0), .o_rgb1(rgb1), .o_row(row),
        .o_frame_done(frame_done),
`ifdef HUB75_BUFFER_SWAP_EN
        .i_swap_req(swap_req), .o_bank(bank),
`endif
        .o_dbg_state(dbg_state)
    );

    // Framebuffer model: R0=col, G0=row, B0=3, R1=~col, G1=0, B1=1.
    logic [11:0] mem [2**AW];
    initial begin
        ram_if.ram_data = '0;
        for (int a = 0; a < 2**AW; a++) begin
            logic [1:0] c, r;
            c = 2'(a & 3);
            r = 2'((a >> 2) & 1);
            mem[a] = {~c, 2'b00, 2'b01, c, r, 2'b11};
        end
    end
    always @(posedge clk) begin
        if (ram_if.ram_rd) ram_if.ram_data <= mem[ram_if.ram_addr];
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [5:0]  exp_q[$];
    logic [31:0] exp_addr_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pins();
        return {20'b0, sclk, lat, oe_n, rgb0, rgb1, row, ram_if.ram_rd, frame_done};
    endfunction

    // ---------------- trace recorder ----------------
    logic        tr_sclk [256];
    logic        tr_lat  [256];
    logic        tr_oe   [256];
    logic        tr_rd   [256];
    logic        tr_fd   [256];
    logic [5:0]  tr_rgb  [256];
    logic [31:0] tr_addr [256];
    logic [31:0] tr_row  [256];
    logic [31:0] tr_state[256];

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tr_sclk[i]  = sclk;
            tr_lat[i]   = lat;
            tr_oe[i]    = oe_n;
            tr_rd[i]    = ram_if.ram_rd;
            tr_fd[i]    = frame_done;
            tr_rgb[i]   = {rgb0, rgb1};
            tr_addr[i]  = 32'(ram_if.ram_addr);
            tr_row[i]   = 32'(row);
            tr_state[i] = 32'(dbg_state);
        end
    endtask

    function automatic int cnt_oe_low(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) if (!tr_oe[i]) n++;
        return n;
    endfunction
    function automatic int cnt_lat(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) if (tr_lat[i]) n++;
        return n;
    endfunction
    function automatic int cnt_rd(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) if (tr_rd[i]) n++;
        return n;
    endfunction
    function automatic int cnt_fd(input int a, input int b);
        int n = 0;
        for (int i = a; i < b; i++) if (tr_fd[i]) n++;
        return n;
    endfunction
    function automatic bit is_edge(input int i);
        return tr_sclk[i] && (i == 0 || !tr_sclk[i-1]);
    endfunction

    task automatic check_reset_pins(input string tag);
        chk({tag, "_pins"}, pins(), 32'h200);
        chk({tag, "_addr"}, 32'(ram_if.ram_addr), 32'h0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
`ifdef HUB75_BUFFER_SWAP_EN
        chk({tag, "_bank"}, 32'(bank), 32'h0);
`endif
    endtask

`ifdef HUB75_BUFFER_SWAP_EN
    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask
`endif

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        rst = 1'b1;
        en  = 1'b1;
`ifdef HUB75_BUFFER_SWAP_EN
        swap_req = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk);
            check_reset_pins("reset");
        end

        // Full frame and a bit: plane 0 = cycles 0..23, plane 1 = 24..51, row 1 from 52, wrap at 104.
        rst = 1'b0;
        record(220);
        chk("first_rd", 32'(tr_rd[0]), 32'h1);
        chk("first_addr", tr_addr[0], 32'h0);
        chk("sclk_c3", 32'(tr_sclk[3]), 32'h0);
        chk("sclk_c4", 32'(tr_sclk[4]), 32'h1);

        // {rgb0,rgb1} at each rising sclk across one frame.
        exp_q = '{6'o15, 6'o51, 6'o15, 6'o51,
                  6'o14, 6'o14, 6'o50, 6'o50,
                  6'o35, 6'o71, 6'o35, 6'o71,
                  6'o14, 6'o14, 6'o50, 6'o50};
        for (int i = 0; i < 104; i++) begin
            if (is_edge(i)) begin
                if (exp_q.size() > 0) chk("rgb_edge", 32'(tr_rgb[i]), 32'(exp_q.pop_front()));
                else chk("extra_edge", 32'(i), 32'hFFFF);
            end
        end
        chk("edges_missing", 32'(exp_q.size()), 32'h0);

        chk("lat_p0", 32'(cnt_lat(0, 24)), 32'd2);
        chk("lat_c18", 32'(tr_lat[18]), 32'h1);
        chk("lat_frame", 32'(cnt_lat(0, 104)), 32'd8);
        chk("oe_p0", 32'(cnt_oe_low(0, 24)), 32'd4);
        chk("oe_p1", 32'(cnt_oe_low(24, 52)), 32'd8);
        chk("oe_c19", 32'(tr_oe[19]), 32'h1);
        chk("oe_c20", 32'(tr_oe[20]), 32'h0);
        chk("no_rd_display", 32'(cnt_rd(18, 24)), 32'h0);
        chk("p1_fetch", 32'(tr_rd[24]), 32'h1);
        chk("row1_fetch", 32'(tr_rd[52]), 32'h1);

        exp_addr_q = '{32'd4, 32'd5, 32'd6, 32'd7};
        for (int i = 52; i < 76; i++) begin
            if (tr_rd[i]) begin
                if (exp_addr_q.size() > 0) chk("row1_addr", tr_addr[i], exp_addr_q.pop_front());
                else chk("row1_extra_rd", tr_addr[i], 32'hFFFF);
            end
        end
        chk("row1_addr_missing", 32'(exp_addr_q.size()), 32'h0);

        chk("row_c18", tr_row[18], 32'd0);
        chk("row_c69", tr_row[69], 32'd0);
        chk("row_c70", tr_row[70], 32'd1);
        chk("row_c122", tr_row[122], 32'd0);
        chk("fd_count", 32'(cnt_fd(0, 220)), 32'd2);
        chk("fd_c104", 32'(tr_fd[104]), 32'h1);
        chk("fd_c208", 32'(tr_fd[208]), 32'h1);

        // Reset while column 2 is being shifted.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (ram_if.ram_rd && ram_if.ram_addr[1:0] == 2'd2) found = 1'b1;
        end
        chk("col2_seen", 32'(found), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_pins("midrst");
        rst = 1'b0;
        record(60);
        chk("restart_rd", 32'(tr_rd[0]), 32'h1);
        chk("restart_addr", tr_addr[0], 32'h0);
        chk("restart_rgb", 32'(tr_rgb[4]), 32'o15);
        chk("restart_row", tr_row[18], 32'd0);
        chk("restart_oe_p0", 32'(cnt_oe_low(0, 24)), 32'd4);

        // Enable dropped during row-1 shift: the plane completes, then the scanner idles.
        en = 1'b0;
        record(40);
        chk("dis_oe", 32'(cnt_oe_low(0, 40)), 32'd4);
        chk("dis_lat", 32'(cnt_lat(0, 40)), 32'd2);
        chk("dis_no_rd", 32'(cnt_rd(16, 40)), 32'h0);
        chk("dis_idle", tr_state[39], 32'(ST_IDLE));

`ifdef HUB75_BUFFER_SWAP_EN
        begin
            bit ok;
            en = 1'b1;
            repeat (30) @(negedge clk);
            swap_req = 1'b1;
            @(negedge clk);
            swap_req = 1'b0;
            wait_fd(ok);
            chk("swap_fd1", 32'(ok), 32'h1);
            chk("swap_bank1", 32'(bank), 32'h1);
            chk("swap_addr1", 32'(ram_if.ram_addr), 32'h8);
            swap_req = 1'b1;
            @(negedge clk);
            swap_req = 1'b0;
            wait_fd(ok);
            chk("swap_fd2", 32'(ok), 32'h1);
            chk("swap_bank2", 32'(bank), 32'h0);
            chk("swap_addr2", 32'(ram_if.ram_addr), 32'h0);
            wait_fd(ok);
            chk("swap_fd3", 32'(ok), 32'h1);
            chk("swap_bank3", 32'(bank), 32'h0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
